axi_rd_master_arb: RTL
======================

// Module: axi_rd_master_arb
// PURPOSE
//  Parametrised AXI4 read master with two arbitrated requestors: instruction fetch (IF) and load unit (LSU).
//  Round-robin grant; one outstanding single-beat transaction.
//  Returns instruction lane or full data word plus an error flag per requestor.
//  Sits between pipeline IF/MEM stages and the AXI crossbar; replaces the fixed IF->MEM read sequencer.
// PARAMETERS
//  ADDR_W   64  AXI/requestor address width
//  DATA_W   64  RDATA width, power of 2, >=32; MAXSZ = log2(DATA_W/8)
//  ID_W     4   ARID/RID width; IF uses ID 0, LSU uses ID 1
// PORTS
//  clk             in   1       clock
//  rstn            in   1       synchronous active-low reset
//  if_req_valid    in   1       IF read request
//  if_req_ready    out  1       IF request accepted this cycle
//  if_req_addr     in   ADDR_W  IF address, 4-byte aligned
//  if_resp_valid   out  1       one-cycle pulse: instruction returned
//  if_resp_instr   out  32      instruction word (lane selected by addr)
//  if_resp_err     out  1       RRESP!=OKAY for this fetch
//  lsu_req_valid   in   1       LSU read request
//  lsu_req_ready   out  1       LSU request accepted this cycle
//  lsu_req_addr    in   ADDR_W  LSU address
//  lsu_req_size    in   3       log2 bytes; clamped to MAXSZ
//  lsu_resp_valid  out  1       one-cycle pulse: load data returned
//  lsu_resp_data   out  DATA_W  raw RDATA
//  lsu_resp_err    out  1       RRESP!=OKAY for this load
//  stray_rid       out  1       sticky: R beat seen with unexpected RID or outside R state
//  ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARPROT  out  ID_W/ADDR_W/8/3/2/3   AR payload
//  ARVALID out 1 / ARREADY in 1   AR handshake
//  RID/RDATA/RRESP/RLAST  in  ID_W/DATA_W/2/1   R payload
//  RVALID in 1 / RREADY out 1     R handshake
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; last_grant=LSU (IF wins first tie); pending transaction abandoned, its late R beats set stray_rid.
//  FSM: IDLE -> AR on request accept; AR -> R on ARVALID&&ARREADY; R -> IDLE on RVALID&&RLAST&&RID==expected.
//  IDLE: req_ready is combinational, high only for the granted requestor while its valid is high.
//   - Only one requestor valid: grant it.
//   - Both valid: grant the one not in last_grant; last_grant updates on every accept.
//   - Accept latches addr, size and requestor into AR registers.
//  AR: ARVALID=1 from the cycle after accept.
//   - Payload held stable until ARREADY.
//   - ARLEN=0, ARBURST=INCR(01).
//   - IF: ARID=0, ARSIZE=010, ARPROT=100.
//   - LSU: ARID=1, ARSIZE=min(lsu_req_size,MAXSZ), ARPROT=000.
//   - ARVALID drops the cycle after the handshake.
//  R: RREADY=1 only in R; RREADY=0 in IDLE and AR.
//   - Beat with RID!=expected: consumed, discarded, sets stray_rid.
//   - RVALID outside R (RREADY=0) is not consumed but sets stray_rid.
//  Completion: registered; RLAST beat at cycle M -> resp_valid pulse at M+1.
//   - err=(RRESP!=00); data held until the next completion.
//   - IF lane = RDATA[32*k +: 32], k = addr[MAXSZ-1:2] (k=0 when DATA_W=32).
//  Latency: accept N -> ARVALID N+1; ARREADY N+1 -> RREADY N+2.
//   - RLAST M -> resp M+1; IDLE at M+1, next accept possible at M+1.
//  Requests while busy: req_ready=0; requestors hold valid/addr stable until ready.
//  Reset mid-AR/R: returns to IDLE next edge; no resp pulse issued.
// TESTING
//  IF req 0x8000_0004, ARREADY same cycle, RDATA=0x1111_2222_3333_4444 OKAY RLAST 2 cycles later -> ARID=0 ARSIZE=2, if_resp_instr=0x11112222, err=0
//  IF and LSU both valid from reset, 3 back-to-back pairs -> grant order IF,LSU,IF,LSU,IF,LSU
//  LSU req size=3 addr 0x100, ARREADY low 5 cycles -> ARVALID/ARADDR/ARSIZE stable all 5, one handshake
//  LSU read answered RRESP=10 -> lsu_resp_valid pulse, lsu_resp_err=1, if_resp_valid stays 0
//  In R, inject RID=3 beat then RID=1 RLAST -> stray_rid=1, lsu_resp_data = second beat
//  rstn low 1 cycle while in R, then old RVALID -> all outputs 0, no resp pulse, stray_rid=1 after beat

Source files
------------

// File: rtl/axi_rd_master_arb.sv
// axi_rd_master_arb
// AXI4 read master shared by the instruction-fetch (IF) and load (LSU) ports.
// Round-robin arbitration, one outstanding single-beat read at a time.
// Returns the selected 32-bit instruction lane to IF and the raw data word to LSU.
module axi_rd_master_arb #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rstn,
    // IF requestor
    input  logic              i_if_req_valid,
    output logic              o_if_req_ready,
    input  logic [ADDR_W-1:0] i_if_req_addr,
    output logic              o_if_resp_valid,
    output logic [31:0]       o_if_resp_instr,
    output logic              o_if_resp_err,
    // LSU requestor
    input  logic              i_lsu_req_valid,
    output logic              o_lsu_req_ready,
    input  logic [ADDR_W-1:0] i_lsu_req_addr,
    input  logic [2:0]        i_lsu_req_size,
    output logic              o_lsu_resp_valid,
    output logic [DATA_W-1:0] o_lsu_resp_data,
    output logic              o_lsu_resp_err,
    output logic              o_stray_rid,
    // AXI AR channel
    output logic [ID_W-1:0]   o_arid,
    output logic [ADDR_W-1:0] o_araddr,
    output logic [7:0]        o_arlen,
    output logic [2:0]        o_arsize,
    output logic [1:0]        o_arburst,
    output logic [2:0]        o_arprot,
    output logic              o_arvalid,
    input  logic              i_arready,
    // AXI R channel
    input  logic [ID_W-1:0]   i_rid,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rlast,
    input  logic              i_rvalid,
    output logic              o_rready
);

    localparam int              MAXSZ   = $clog2(DATA_W / 8);
    localparam logic [2:0]      MAXSZ_3 = 3'(MAXSZ);
    localparam logic [ID_W-1:0] ID_IF   = '0;
    localparam logic [ID_W-1:0] ID_LSU  = ID_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic                r_last_grant_lsu;
    logic                r_is_lsu;
    logic [ID_W-1:0]     r_arid;
    logic [ADDR_W-1:0]   r_araddr;
    logic [2:0]          r_arsize;
    logic [2:0]          r_arprot;
    logic                r_if_resp_valid;
    logic [31:0]         r_if_resp_instr;
    logic                r_if_resp_err;
    logic                r_lsu_resp_valid;
    logic [DATA_W-1:0]   r_lsu_resp_data;
    logic                r_lsu_resp_err;
    logic                r_stray_rid;

    logic                w_grant_if;
    logic                w_grant_lsu;
    logic                w_accept;
    logic                w_id_match;
    logic                w_done;
    logic                w_stray;
    logic [2:0]          w_lsu_size;
    logic [31:0]         w_if_lane;

    // IF wins when it is alone or when LSU took the previous grant.
    assign w_grant_if  = i_if_req_valid && (!i_lsu_req_valid || r_last_grant_lsu);
    assign w_grant_lsu = i_lsu_req_valid && !w_grant_if;
    assign w_accept    = (r_state == S_IDLE) && (w_grant_if || w_grant_lsu);

    assign w_id_match  = (i_rid == r_arid);
    assign w_done      = (r_state == S_R) && i_rvalid && w_id_match && i_rlast;
    // Any beat we did not ask for: wrong ID while waiting, or any beat outside R.
    assign w_stray     = i_rvalid && ((r_state != S_R) || !w_id_match);

    assign w_lsu_size  = (i_lsu_req_size > MAXSZ_3) ? MAXSZ_3 : i_lsu_req_size;

    // Instruction lane is picked by the address bits between the word and bus offsets.
    generate
        if (DATA_W == 32) begin : g_one_lane
            assign w_if_lane = i_rdata[31:0];
        end else begin : g_lanes
            logic [MAXSZ-3:0] w_lane_idx;
            assign w_lane_idx = r_araddr[MAXSZ-1:2];
            assign w_if_lane  = i_rdata[{w_lane_idx, 5'b00000} +: 32];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only, matching the rest of the pipeline.
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept)  w_next_state = S_AR;
            S_AR:    if (i_arready) w_next_state = S_R;
            S_R:     if (w_done)    w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs; readies are held low during reset so no request is accepted then dropped.
    always_comb begin
        o_if_req_ready  = 1'b0;
        o_lsu_req_ready = 1'b0;
        o_arvalid       = 1'b0;
        o_arburst       = 2'b00;
        o_rready        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                o_if_req_ready  = rstn && w_grant_if;
                o_lsu_req_ready = rstn && w_grant_lsu;
            end
            S_AR: begin
                o_arvalid = 1'b1;
                o_arburst = 2'b01;
            end
            S_R:     o_rready = 1'b1;
            default: ;
        endcase
    end

    // AR payload capture, arbitration history, completion registers and stray flag.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_last_grant_lsu <= 1'b1;
            r_is_lsu         <= 1'b0;
            r_arid           <= '0;
            r_araddr         <= '0;
            r_arsize         <= '0;
            r_arprot         <= '0;
            r_if_resp_valid  <= 1'b0;
            r_if_resp_instr  <= '0;
            r_if_resp_err    <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
            r_lsu_resp_data  <= '0;
            r_lsu_resp_err   <= 1'b0;
            r_stray_rid      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here samples pre-edge values.
            r_if_resp_valid  <= w_done && !r_is_lsu;
            r_lsu_resp_valid <= w_done && r_is_lsu;
            if (w_accept) begin
                r_last_grant_lsu <= w_grant_lsu;
                r_is_lsu         <= w_grant_lsu;
                r_arid           <= w_grant_lsu ? ID_LSU : ID_IF;
                r_araddr         <= w_grant_lsu ? i_lsu_req_addr : i_if_req_addr;
                r_arsize         <= w_grant_lsu ? w_lsu_size : 3'b010;
                r_arprot         <= w_grant_lsu ? 3'b000 : 3'b100;
            end
            if (w_done) begin
                if (r_is_lsu) begin
                    r_lsu_resp_data <= i_rdata;
                    r_lsu_resp_err  <= (i_rresp != 2'b00);
                end else begin
                    r_if_resp_instr <= w_if_lane;
                    r_if_resp_err   <= (i_rresp != 2'b00);
                end
            end
            if (w_stray) r_stray_rid <= 1'b1;
        end
    end

    assign o_arid           = r_arid;
    assign o_araddr         = r_araddr;
    assign o_arlen          = 8'd0;
    assign o_arsize         = r_arsize;
    assign o_arprot         = r_arprot;
    assign o_if_resp_valid  = r_if_resp_valid;
    assign o_if_resp_instr  = r_if_resp_instr;
    assign o_if_resp_err    = r_if_resp_err;
    assign o_lsu_resp_valid = r_lsu_resp_valid;
    assign o_lsu_resp_data  = r_lsu_resp_data;
    assign o_lsu_resp_err   = r_lsu_resp_err;
    assign o_stray_rid      = r_stray_rid;

endmodule
